// File: rtl/lane_runner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lane_runner_pkg
//  Description : Cell codes, action codes, FSM state encoding and the walk
//                priority helper shared by the lane runner solver files.
//  Revision    : 1.0 - initial release
// ============================================================================
package lane_runner_pkg;

  // Obstacle map cell codes
  localparam logic [1:0] CELL_ROAD  = 2'd0;
  localparam logic [1:0] CELL_LOW   = 2'd1;
  localparam logic [1:0] CELL_HIGH  = 2'd2;
  localparam logic [1:0] CELL_TRAIN = 2'd3;

  // Action codes
  localparam logic [1:0] ACT_FWD   = 2'd0;
  localparam logic [1:0] ACT_RIGHT = 2'd1;
  localparam logic [1:0] ACT_LEFT  = 2'd2;
  localparam logic [1:0] ACT_JUMP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SOLVE = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  // Action tried at a given rank during the walk: forward, jump, right, left
  function automatic logic [1:0] walk_action(input int rank);
    case (rank)
      0:       walk_action = ACT_FWD;
      1:       walk_action = ACT_JUMP;
      2:       walk_action = ACT_RIGHT;
      default: walk_action = ACT_LEFT;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_runner_solver_if.sv
`default_nettype none
// ============================================================================
//  Module      : lane_runner_solver_if
//  Description : Map-input and action-output bundle of the lane runner
//                solver. master = map source / action sink, slave = solver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lane_runner_solver_if #(
  parameter int LANES = 4,
  parameter int LW    = $clog2(LANES)
);
  logic                 in_valid;
  logic [LW-1:0]        init;
  logic [2*LANES-1:0]   in_map;
  logic                 out_valid;
  logic [1:0]           out;
  logic [LW-1:0]        lane_out;
  logic                 no_path;

  modport master (
    output in_valid, init, in_map,
    input  out_valid, out, lane_out, no_path
  );

  modport slave (
    input  in_valid, init, in_map,
    output out_valid, out, lane_out, no_path
  );
endinterface
`default_nettype wire

// File: rtl/lane_runner_solver_step_rule.sv
`default_nettype none
// ============================================================================
//  Module      : lane_step_rule
//  Description : Combinational legality check of one runner step, given the
//                source cell, destination cell, action and lane range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_step_rule
  import lane_runner_pkg::*;
(
  input  wire logic [1:0] src_cell,
  input  wire logic [1:0] dst_cell,
  input  wire logic [1:0] action,
  input  wire logic       dst_in_range,
  output logic            legal
);

  logic w_change;

  // A step is legal unless one of the blocking rules applies
  always_comb begin
    w_change = (action == ACT_RIGHT) || (action == ACT_LEFT);
    legal = dst_in_range
         && (dst_cell != CELL_TRAIN)
         && !(w_change && ((dst_cell == CELL_LOW) || (dst_cell == CELL_HIGH)))
         && !((action == ACT_FWD) && (dst_cell == CELL_LOW))
         && !((action == ACT_JUMP) && (dst_cell == CELL_HIGH))
         && !((action == ACT_JUMP) && (src_cell == CELL_LOW));
  end

endmodule
`default_nettype wire

// File: rtl/lane_runner_solver.sv
`default_nettype none
// ============================================================================
//  Module      : lane_runner_solver
//  Description : Loads a LANES x COLS obstacle map one column per cycle,
//                computes backward reachability one column per cycle, then
//                streams the priority-ordered action sequence or pulses
//                no_path when the start position cannot reach the end.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_runner_solver
  import lane_runner_pkg::*;
#(
  parameter int LANES = 4,
  parameter int COLS  = 64,
  parameter int LW    = $clog2(LANES)
) (
  input wire logic             clk,
  input wire logic             rst,
  lane_runner_solver_if.slave  bus
);

  localparam int CW = $clog2(COLS);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [2*LANES-1:0]   map_q [COLS];
  logic [2*LANES-1:0]   map_d [COLS];
  logic [LANES-1:0]     ok_q  [COLS];
  logic [LANES-1:0]     ok_d  [COLS];
  logic                 out_valid_q, out_valid_d;
  logic [1:0]           out_q, out_d;
  logic [LW-1:0]        lane_out_q, lane_out_d;
  logic                 no_path_q, no_path_d;

  // cnt_q names the source column in SOLVE and EMIT; w_nxt is the column after it
  logic [CW-1:0]        w_nxt;
  logic [2*LANES-1:0]   w_src_col;
  logic [2*LANES-1:0]   w_dst_col;
  logic [LANES-1:0]     w_ok_nxt;
  logic [LANES-1:0]     w_ok_col;
  logic [4*LANES-1:0]   w_solve_ok;
  logic [1:0]           w_src_cell;
  logic [3:0]           w_walk_ok;
  logic [LW-1:0]        w_walk_dst [4];

  assign w_nxt      = cnt_q + CW'(1);
  assign w_src_col  = map_q[cnt_q];
  assign w_dst_col  = map_q[w_nxt];
  assign w_ok_nxt   = ok_q[w_nxt];
  assign w_src_cell = w_src_col[{lane_q, 1'b0} +: 2];

  // Reachability of every lane of the source column: any legal step into an ok cell
  for (genvar l = 0; l < LANES; l++) begin : g_solve_lane
    for (genvar a = 0; a < 4; a++) begin : g_solve_act
      localparam int DST =
          (a == 1) ? ((l < LANES - 1) ? l + 1 : l) :
          (a == 2) ? ((l > 0) ? l - 1 : l) : l;
      localparam bit IN_RANGE =
          (a == 1) ? (l < LANES - 1) :
          (a == 2) ? (l > 0) : 1'b1;
      localparam logic [1:0] ACT = 2'(a);
      logic w_legal;

      lane_step_rule u_rule (
        .src_cell     (w_src_col[2*l +: 2]),
        .dst_cell     (w_dst_col[2*DST +: 2]),
        .action       (ACT),
        .dst_in_range (IN_RANGE),
        .legal        (w_legal)
      );

      assign w_solve_ok[4*l + a] = w_legal & w_ok_nxt[DST];
    end
    assign w_ok_col[l] = |w_solve_ok[4*l +: 4];
  end

  // Candidate steps of the walk from the current lane, in priority order
  for (genvar i = 0; i < 4; i++) begin : g_walk
    localparam logic [1:0] ACT = walk_action(i);
    logic          w_in_range;
    logic [LW-1:0] w_dst;
    logic          w_legal;

    if (ACT == ACT_RIGHT) begin : g_right
      assign w_in_range = (lane_q != LW'(LANES - 1));
      assign w_dst      = w_in_range ? lane_q + LW'(1) : lane_q;
    end else if (ACT == ACT_LEFT) begin : g_left
      assign w_in_range = (lane_q != '0);
      assign w_dst      = w_in_range ? lane_q - LW'(1) : lane_q;
    end else begin : g_same
      assign w_in_range = 1'b1;
      assign w_dst      = lane_q;
    end

    lane_step_rule u_rule (
      .src_cell     (w_src_cell),
      .dst_cell     (w_dst_col[{w_dst, 1'b0} +: 2]),
      .action       (ACT),
      .dst_in_range (w_in_range),
      .legal        (w_legal)
    );

    assign w_walk_dst[i] = w_dst;
    assign w_walk_ok[i]  = w_legal & w_ok_nxt[w_dst];
  end

  // Next-state, storage update and output decode for the load/solve/emit sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    map_d       = map_q;
    ok_d        = ok_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    lane_out_d  = '0;
    no_path_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          map_d[0] = bus.in_map;
          lane_d   = bus.init;
          cnt_d    = CW'(1);
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (!bus.in_valid) begin
          // Short map: drop it silently
          state_d = ST_IDLE;
        end else begin
          map_d[cnt_q] = bus.in_map;
          if (cnt_q == CW'(COLS - 1)) begin
            for (int l = 0; l < LANES; l++) begin
              ok_d[COLS-1][l] = (bus.in_map[2*l +: 2] != CELL_TRAIN);
            end
            cnt_d   = CW'(COLS - 2);
            state_d = ST_SOLVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_SOLVE: begin
        ok_d[cnt_q] = w_ok_col;
        if (cnt_q == '0) begin
          if (w_ok_col[lane_q] && (w_src_cell == CELL_ROAD)) begin
            state_d = ST_EMIT;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_EMIT: begin
        out_valid_d = 1'b1;
        out_d       = ACT_FWD;
        lane_out_d  = lane_q;
        // Lowest rank wins, so scan from the back
        for (int i = 3; i >= 0; i--) begin
          if (w_walk_ok[i]) begin
            out_d      = walk_action(i);
            lane_out_d = w_walk_dst[i];
          end
        end
        lane_d = lane_out_d;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(COLS - 2)) begin
          state_d = ST_IDLE;
        end
      end

      ST_FAIL: begin
        no_path_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      map_q       <= '{default: '0};
      ok_q        <= '{default: '0};
      out_valid_q <= 1'b0;
      out_q       <= '0;
      lane_out_q  <= '0;
      no_path_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      map_q       <= map_d;
      ok_q        <= ok_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      lane_out_q  <= lane_out_d;
      no_path_q   <= no_path_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.lane_out  = lane_out_q;
  assign bus.no_path   = no_path_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_runner_solver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_runner_solver
//  Description : Directed bench for lane_runner_solver: a default 4x64
//                instance and a 6x16 instance, driven from a vector table of
//                obstacle rectangles with hand-computed action sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_runner_solver;

  // One map: cells in columns col_lo..col_hi of the lanes in lane_mask carry
  // code; every other cell is road. Expected walk is forward except at
  // exp_step, which issues exp_act; from exp_step on the lane is exp_lane.
  typedef struct {
    string name;
    bit    use_b;
    int    init;
    int    col_lo;
    int    col_hi;
    int    lane_mask;
    int    code;
    bit    exp_fail;
    int    exp_step;
    int    exp_act;
    int    exp_lane;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [10];

  lane_runner_solver_if #(.LANES(4)) ifa ();
  lane_runner_solver_if #(.LANES(6)) ifb ();

  lane_runner_solver #(.LANES(4), .COLS(64)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  lane_runner_solver #(.LANES(6), .COLS(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string what, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", what, got, want);
    end
  endtask

  function automatic logic [15:0] column(input vec_t v, input int k, input int lanes);
    logic [15:0] col;
    col = '0;
    for (int l = 0; l < lanes; l++) begin
      if (k >= v.col_lo && k <= v.col_hi && (((v.lane_mask >> l) & 1) != 0)) begin
        col[2*l +: 2] = 2'(v.code);
      end
    end
    return col;
  endfunction

  task automatic drive(input bit use_b, input logic vld, input int init, input logic [15:0] col);
    if (use_b) begin
      ifb.in_valid = vld;
      ifb.init     = 3'(init);
      ifb.in_map   = col[11:0];
    end else begin
      ifa.in_valid = vld;
      ifa.init     = 2'(init);
      ifa.in_map   = col[7:0];
    end
  endtask

  task automatic sample(input bit use_b, output logic ov, output logic [1:0] oc,
                        output logic [2:0] ol, output logic np);
    if (use_b) begin
      ov = ifb.out_valid; oc = ifb.out; ol = ifb.lane_out; np = ifb.no_path;
    end else begin
      ov = ifa.out_valid; oc = ifa.out; ol = {1'b0, ifa.lane_out}; np = ifa.no_path;
    end
  endtask

  // Streams all columns; the negedge after the last column is t=0 (just after E0)
  task automatic load_map(input vec_t v);
    int cols  = v.use_b ? 16 : 64;
    int lanes = v.use_b ? 6 : 4;
    int busy  = 0;
    logic ov, np;
    logic [1:0] oc;
    logic [2:0] ol;
    for (int k = 0; k < cols; k++) begin
      @(negedge clk);
      drive(v.use_b, 1'b1, v.init, column(v, k, lanes));
      sample(v.use_b, ov, oc, ol, np);
      if (ov) busy++;
    end
    check($sformatf("%s valid_during_load", v.name), busy, 0);
    @(negedge clk);
    drive(v.use_b, 1'b0, 0, '0);
  endtask

  // Checks every cycle after E0 against the expected walk
  task automatic watch_map(input vec_t v);
    int cols   = v.use_b ? 16 : 64;
    int nvalid = 0;
    int first  = -1;
    int step, exp_oc, exp_ln;
    logic exp_ov, exp_np, ov, np;
    logic [1:0] oc;
    logic [2:0] ol;
    for (int t = 1; t <= 2*cols + 2; t++) begin
      @(negedge clk);
      sample(v.use_b, ov, oc, ol, np);
      exp_ov = !v.exp_fail && (t >= cols) && (t <= 2*cols - 2);
      exp_np = v.exp_fail && (t == cols);
      check($sformatf("%s out_valid t=%0d", v.name, t), ov, exp_ov);
      check($sformatf("%s no_path t=%0d", v.name, t), np, exp_np);
      if (ov === 1'b1) begin
        nvalid++;
        if (first < 0) first = t;
      end
      if (exp_ov) begin
        step   = t - cols + 1;
        exp_oc = (step == v.exp_step) ? v.exp_act : 0;
        exp_ln = (v.exp_step > 0 && step >= v.exp_step) ? v.exp_lane : v.init;
        check($sformatf("%s out step=%0d", v.name, step), oc, exp_oc);
        check($sformatf("%s lane_out step=%0d", v.name, step), ol, exp_ln);
      end else begin
        check($sformatf("%s out idle t=%0d", v.name, t), oc, 0);
        check($sformatf("%s lane_out idle t=%0d", v.name, t), ol, 0);
      end
    end
    check($sformatf("%s valid_count", v.name), nvalid, v.exp_fail ? 0 : cols - 1);
    check($sformatf("%s first_valid", v.name), first, v.exp_fail ? -1 : cols);
  endtask

  task automatic run_vec(input vec_t v);
    load_map(v);
    watch_map(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic ov, np;
    logic [1:0] oc;
    logic [2:0] ol;
    int bad;

    //          name             B  init lo  hi mask code fail step act lane
    vecs[0] = '{"all_zero",       0, 2,   0,  0, 0,  0,   0,   -1,  0,  2};
    vecs[1] = '{"jump_low",       0, 1,   5,  5, 2,  1,   0,    5,  3,  1};
    vecs[2] = '{"train_right",    0, 0,   3,  6, 1,  3,   0,    3,  1,  1};
    vecs[3] = '{"wall",           0, 0,  10, 10, 15, 3,   1,   -1,  0,  0};
    vecs[4] = '{"after_wall",     0, 0,   0,  0, 0,  0,   0,   -1,  0,  0};
    vecs[5] = '{"fwd_into_high",  0, 2,   7,  7, 4,  2,   0,   -1,  0,  2};
    vecs[6] = '{"start_low",      0, 3,   0,  0, 8,  1,   1,   -1,  0,  3};
    vecs[7] = '{"top_edge_left",  0, 3,  20, 63, 8,  3,   0,   20,  2,  2};
    vecs[8] = '{"last_col_train", 0, 1,  63, 63, 2,  3,   0,   63,  1,  2};
    vecs[9] = '{"six_lane",       1, 5,   2, 15, 32, 3,   0,    2,  2,  4};

    drive(1'b0, 1'b0, 0, '0);
    drive(1'b1, 1'b0, 0, '0);

    // Reset state
    #2;
    sample(1'b0, ov, oc, ol, np);
    check("reset out_valid", ov, 0);
    check("reset out", oc, 0);
    check("reset lane_out", ol, 0);
    check("reset no_path", np, 0);
    sample(1'b1, ov, oc, ol, np);
    check("reset b out_valid", ov, 0);
    check("reset b no_path", np, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Reset in the middle of EMIT, at the step that carries a left move
    load_map(vecs[7]);
    for (int t = 1; t <= 64 + 19; t++) @(negedge clk);
    sample(1'b0, ov, oc, ol, np);
    check("pre_rst out_valid", ov, 1);
    check("pre_rst out", oc, 2);
    check("pre_rst lane_out", ol, 2);
    rst = 1'b1;
    #1;
    sample(1'b0, ov, oc, ol, np);
    check("async_rst out_valid", ov, 0);
    check("async_rst out", oc, 0);
    check("async_rst lane_out", ol, 0);
    check("async_rst no_path", np, 0);
    @(negedge clk);
    @(negedge clk);
    sample(1'b0, ov, oc, ol, np);
    check("held_rst out_valid", ov, 0);
    rst = 1'b0;
    run_vec(vecs[1]);

    // Map cut short after 10 columns: nothing may come out
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1, '0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 0, '0);
    bad = 0;
    for (int t = 0; t < 2*64 + 4; t++) begin
      @(negedge clk);
      sample(1'b0, ov, oc, ol, np);
      if (ov !== 1'b0 || np !== 1'b0) bad++;
    end
    check("early_drop quiet_cycles", bad, 0);
    run_vec(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
